test_check_pattern: RTL
=======================

// Module: test_check_pattern
// PURPOSE
//  Receive-side checker for the 0x88B5 test-pattern stream. Sits downstream of the Ethernet RX
//  header parser, consumes header + payload AXI-S, and verifies every frame field. Reports the
//  timestamp and packet index, plus per-frame pass/fail, good/bad/lost counters for debug/ILA.
// PARAMETERS
//  DATA_LENGTH  64  number of incrementing data bytes per frame
//  DATA_WIDTH   8   payload width (byte stream only)
//  COUNT_WIDTH  32  width of statistics counters
// PORTS
//  clk                        in   1     clock
//  rst                        in   1     synchronous reset, active-high
//  s_eth_hdr_valid            in   1     header valid
//  s_eth_hdr_ready            out  1     header accepted
//  s_eth_dest_mac             in   48    received destination MAC (unused; for ILA)
//  s_eth_src_mac              in   48    received source MAC (unused; for ILA)
//  s_eth_type                 in   16    received EtherType
//  s_eth_payload_axis_tdata   in   8     payload byte
//  s_eth_payload_axis_tvalid  in   1     payload valid
//  s_eth_payload_axis_tready  out  1     payload ready
//  s_eth_payload_axis_tlast   in   1     last payload byte
//  s_eth_payload_axis_tuser   in   1     frame error flag from MAC
//  rx_timestamp               out  16    timestamp of current frame
//  rx_timestamp_valid         out  1     1-cycle pulse: rx_timestamp updated
//  rx_packet_index            out  16    packet index of current frame
//  frame_done                 out  1     1-cycle pulse: frame finished
//  frame_ok                   out  1     result of the frame, valid with frame_done
//  good_count/bad_count       out  CW    frames passed / failed, saturating
//  lost_count                 out  CW    packets missing from index sequence, saturating
// BEHAVIOUR
//  Reset: state S_IDLE; all outputs and counters 0; seq_valid=0.
//  Handshake: hdr_ready=1 only in S_IDLE; tready=1 in every state except S_IDLE.
//   Beat = tvalid&&tready. Never back-pressures mid-frame.
//  Payload layout, byte order on wire:
//   flag 0x07 | ts[7:0] | ts[15:8] | 0x00 x3 | idx[7:0] | idx[15:8] | DATA_LENGTH data bytes.
//  FSM (per-state byte counter, cleared on each transition):
//   S_IDLE: on hdr beat -> S_TYPE_FLAG; bad_frame := (s_eth_type != 16'h88B5).
//   S_TYPE_FLAG(1) -> S_TIMESTAMP(2) -> S_3ZEROS(3) -> S_PACKET_INDEX(2) -> S_DATA(DATA_LENGTH) -> S_IDLE.
//   Mismatch: byte != expected (flag, zeros, data) sets bad_frame; parsing continues.
//   Data: first data byte is the seed, unchecked. Byte k must equal seed+k mod 2^8.
//  Frame end:
//   tlast on the final data byte is a normal end.
//   tlast earlier (any state) -> bad, end frame, -> S_IDLE.
//   No tlast on final data byte -> bad; enter S_DROP; consume until tlast -> S_IDLE.
//   tuser=1 on any beat -> bad.
//  On frame end: frame_done=1 for exactly one cycle, the cycle after the tlast beat.
//   frame_ok=!bad_frame at that time. good_count or bad_count increments, saturating at all-ones.
//  Timestamp: rx_timestamp_valid pulses the cycle after the ts[15:8] beat.
//  Sequence check: at frame end, only if frame complete through index bytes.
//   If seq_valid && idx != last+1 (mod 2^16): lost_count += (idx-last-1) mod 2^16 (saturating),
//   and the frame is bad. Then last:=idx, seq_valid:=1.
//  Reset mid-frame: immediate return to S_IDLE; no frame_done emitted.
// TESTING
//  1 Frames idx 0,1,2, ts 0x1234, data 0..63 -> 3 frame_done, frame_ok=1, good=3, rx_timestamp=0x1234.
//  2 EtherType 0x0800 -> payload consumed, frame_ok=0, bad_count=1.
//  3 Data byte 10 corrupted (0x0A->0xFF) -> frame_ok=0; next clean frame ok.
//  4 idx 5 then idx 9 -> lost_count=3, second frame bad.
//  5 tlast at data byte 20 -> frame_done, bad. Then no tlast at byte 63, tlast 4 beats later
//    -> S_DROP, one frame_done, bad.
//  6 Random tvalid gaps + tuser on last beat -> bad; rst mid-frame -> S_IDLE, counters 0, no frame_done.

Source files
------------

// File: rtl/test_check_pattern_if.sv
// test_check_pattern_if: Ethernet header + byte payload AXI-S bundle from the RX header parser
interface test_check_pattern_if;
  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_eth_payload_axis_tdata;
  logic        s_eth_payload_axis_tvalid;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast;
  logic        s_eth_payload_axis_tuser;
  modport master (
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    output s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready
  );
  // MAC addresses are only tapped for debug, so the checker does not import them
  modport slave (
    input  s_eth_hdr_valid, s_eth_type,
    input  s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    output s_eth_hdr_ready, s_eth_payload_axis_tready
  );
endinterface

// File: rtl/test_check_pattern.sv
// test_check_pattern: receive-side checker for the 0x88B5 test-pattern stream
module test_check_pattern #(
  parameter int DATA_LENGTH = 64,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  test_check_pattern_if.slave    eth,
  output logic [15:0]            rx_timestamp,
  output logic                   rx_timestamp_valid,
  output logic [15:0]            rx_packet_index,
  output logic                   frame_done,
  output logic                   frame_ok,
  output logic [COUNT_WIDTH-1:0] good_count,
  output logic [COUNT_WIDTH-1:0] bad_count,
  output logic [COUNT_WIDTH-1:0] lost_count
);
  typedef enum logic [2:0] {S_IDLE, S_TYPE_FLAG, S_TIMESTAMP, S_3ZEROS, S_PACKET_INDEX, S_DATA, S_DROP} state_t;
  state_t                  state, st_next;
  logic [15:0]             cnt, st_len, idx_now, last_idx, gap;
  logic [7:0]              ts_lo, idx_lo;
  logic [DATA_WIDTH-1:0]   seed;
  logic                    bad_frame, seq_valid, idx_done;
  logic                    beat, st_end, last_data, idx_beat, idx_full, byte_bad, end_bad, bad_now, seq_bad, ok;
  logic [COUNT_WIDTH:0]    lost_sum;
  logic [7:0]              tdata;
  assign eth.s_eth_hdr_ready           = state == S_IDLE;
  assign eth.s_eth_payload_axis_tready = state != S_IDLE;
  assign tdata = eth.s_eth_payload_axis_tdata;
  assign beat  = eth.s_eth_payload_axis_tvalid && eth.s_eth_payload_axis_tready;
  always_comb begin
    st_len    = state == S_TIMESTAMP || state == S_PACKET_INDEX ? 16'd2 :
                state == S_3ZEROS ? 16'd3 : state == S_DATA ? 16'(DATA_LENGTH) : 16'd1;
    st_next   = state == S_TYPE_FLAG ? S_TIMESTAMP : state == S_TIMESTAMP ? S_3ZEROS :
                state == S_3ZEROS ? S_PACKET_INDEX : state == S_PACKET_INDEX ? S_DATA : S_DROP;
    st_end    = cnt == st_len - 16'd1;
    last_data = state == S_DATA && st_end;
    idx_beat  = state == S_PACKET_INDEX && st_end;
    idx_now   = idx_beat ? {tdata, idx_lo} : rx_packet_index;
    idx_full  = idx_done || idx_beat;
    byte_bad  = state == S_TYPE_FLAG ? tdata != 8'h07 :
                state == S_3ZEROS ? tdata != 8'h00 :
                state == S_DATA && cnt != 16'd0 ? tdata != seed + cnt[DATA_WIDTH-1:0] : 1'b0;
    // the end of frame must coincide exactly with the final data byte; in S_DROP tlast is expected
    end_bad   = eth.s_eth_payload_axis_tlast ? state != S_DROP && !last_data : last_data;
    bad_now   = bad_frame || byte_bad || eth.s_eth_payload_axis_tuser || end_bad;
    gap       = idx_now - last_idx - 16'd1;
    seq_bad   = idx_full && seq_valid && gap != 16'd0;
    ok        = !(bad_now || seq_bad);
    lost_sum  = {1'b0, lost_count} + (COUNT_WIDTH+1)'(gap);
  end
  always_ff @(posedge clk) begin
    frame_done         <= 1'b0;
    rx_timestamp_valid <= 1'b0;
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bad_frame       <= 1'b0;
      seq_valid       <= 1'b0;
      idx_done        <= 1'b0;
      last_idx        <= '0;
      ts_lo           <= '0;
      idx_lo          <= '0;
      seed            <= '0;
      rx_timestamp    <= '0;
      rx_packet_index <= '0;
      frame_ok        <= 1'b0;
      good_count      <= '0;
      bad_count       <= '0;
      lost_count      <= '0;
    end else if (state == S_IDLE) begin
      if (eth.s_eth_hdr_valid) begin
        state     <= S_TYPE_FLAG;
        cnt       <= '0;
        bad_frame <= eth.s_eth_type != 16'h88B5;
        idx_done  <= 1'b0;
      end
    end else if (beat) begin
      bad_frame <= bad_now;
      cnt       <= st_end ? 16'd0 : cnt + 16'd1;
      if (st_end) state <= st_next;
      if (state == S_TIMESTAMP && !st_end) ts_lo <= tdata;
      if (state == S_TIMESTAMP && st_end) begin
        rx_timestamp       <= {tdata, ts_lo};
        rx_timestamp_valid <= 1'b1;
      end
      if (state == S_PACKET_INDEX && !st_end) idx_lo <= tdata;
      if (idx_beat) begin
        rx_packet_index <= idx_now;
        idx_done        <= 1'b1;
      end
      if (state == S_DATA && cnt == 16'd0) seed <= tdata;
      if (eth.s_eth_payload_axis_tlast) begin
        state      <= S_IDLE;
        cnt        <= '0;
        frame_done <= 1'b1;
        frame_ok   <= ok;
        good_count <= good_count + COUNT_WIDTH'(ok && good_count != '1);
        bad_count  <= bad_count + COUNT_WIDTH'(!ok && bad_count != '1);
        if (idx_full) begin
          if (seq_bad) lost_count <= lost_sum[COUNT_WIDTH] ? '1 : lost_sum[COUNT_WIDTH-1:0];
          last_idx  <= idx_now;
          seq_valid <= 1'b1;
        end
      end
    end
  end
endmodule
